// File: rtl/lc3b_mem_responder_pkg.sv
// Shared types for the LC-3b memory responder: bus words, write masks, op and FSM encodings.
package lc3b_mem_responder_pkg;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_wmask;

   typedef enum logic {
      mem_op_read,
      mem_op_write
   } lc3b_mem_op;

   typedef enum logic [1:0] {
      mr_idle,
      mr_wait,
      mr_resp
   } mr_state_t;

endpackage

// File: rtl/lc3b_mem_responder_if.sv
// CPU-to-memory handshake bundle; the initiator holds a request until the one-cycle mem_resp.
interface lc3b_mem_responder_if;
   import lc3b_mem_responder_pkg::*;

   lc3b_word      mem_address;
   logic          mem_read;
   logic          mem_write;
   lc3b_mem_wmask mem_byte_enable;
   lc3b_word      mem_wdata;
   lc3b_word      mem_rdata;
   logic          mem_resp;

   modport master (
      output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
      input  mem_rdata, mem_resp
   );

   modport slave (
      input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
      output mem_rdata, mem_resp
   );
endinterface

// File: rtl/lc3b_mem_array.sv
// Word RAM built from two byte banks; per-lane writes, read data captured into a register on re.
// One shared index: the controller never reads and writes in the same cycle.
module lc3b_mem_array
   import lc3b_mem_responder_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  lc3b_mem_wmask         wmask,
   input  logic [DEPTH_LOG2-1:0] index,
   input  lc3b_word              wdata,
   input  logic                  re,
   output lc3b_word              rdata
);
   logic [7:0] bank_lo [0:(1<<DEPTH_LOG2)-1];
   logic [7:0] bank_hi [0:(1<<DEPTH_LOG2)-1];
   lc3b_word   rdata_q, rdata_d;

   // RAM contents survive reset; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (we && wmask[0]) bank_lo[index] <= wdata[7:0];
      if (we && wmask[1]) bank_hi[index] <= wdata[15:8];
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = {bank_hi[index], bank_lo[index]};
   end

   always_ff @(posedge clk) begin
      if (reset) rdata_q <= '0;
      else       rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/lc3b_mem_responder.sv
// Memory responder: accepts a read/write, responds LATENCY cycles later with a one-cycle mem_resp.
// No backpressure beyond busy; handshake violations latch the sticky protocol_error.
module lc3b_mem_responder
   import lc3b_mem_responder_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   lc3b_mem_responder_if.slave  mem,
   output logic                 busy,
   output logic                 protocol_error
);
   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("lc3b_mem_responder: LATENCY must be within 1..15");
   end

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   mr_state_t     state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   lc3b_word      addr_q, addr_d;
   lc3b_mem_op    op_q, op_d;
   lc3b_mem_wmask be_q, be_d;
   lc3b_word      wdata_q, wdata_d;
   logic          err_q, err_d;

   logic                  req_rd, req_wr, req_both, op_held, viol;
   logic                  arr_we, arr_re;
   logic [DEPTH_LOG2-1:0] arr_index;
   lc3b_word              arr_rdata;

   assign req_rd   = mem.mem_read && !mem.mem_write;
   assign req_wr   = mem.mem_write && !mem.mem_read;
   assign req_both = mem.mem_read && mem.mem_write;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= mr_idle;
         cnt_q   <= '0;
         addr_q  <= '0;
         op_q    <= mem_op_read;
         be_q    <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         op_q    <= op_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         mr_idle: begin
            if (req_rd || req_wr) begin
               if (LATENCY == 1) begin
                  state_d = mr_resp;
               end else begin
                  state_d = mr_wait;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         mr_wait: begin
            if (cnt_q == 4'd1) state_d = mr_resp;
            else               cnt_d   = cnt_q - 4'd1;
         end
         mr_resp: state_d = mr_idle;
         default: state_d = mr_idle;
      endcase
   end

   // Capture path and violation checker; the transaction runs on captured values regardless.
   always_comb begin
      addr_d  = addr_q;
      op_d    = op_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      if (state_q == mr_idle && (req_rd || req_wr)) begin
         addr_d  = mem.mem_address;
         op_d    = req_wr ? mem_op_write : mem_op_read;
         be_d    = mem.mem_byte_enable;
         wdata_d = mem.mem_wdata;
      end
      op_held = (op_q == mem_op_read) ? req_rd : req_wr;
      viol    = !op_held || (mem.mem_address != addr_q) ||
                (mem.mem_byte_enable != be_q) || (mem.mem_wdata != wdata_q);
      err_d   = err_q || (state_q == mr_idle && req_both) ||
                (state_q != mr_idle && viol);
   end

   // With LATENCY==1 the read fires on the accept edge, so IDLE indexes with the live address.
   always_comb begin
      arr_index = (state_q == mr_idle) ? mem.mem_address[DEPTH_LOG2:1] : addr_q[DEPTH_LOG2:1];
      arr_re    = (state_d == mr_resp) && (op_d == mem_op_read);
      arr_we    = (state_q == mr_resp) && (op_q == mem_op_write) && !reset;
   end

   always_comb begin
      busy           = (state_q != mr_idle);
      mem.mem_resp   = (state_q == mr_resp);
      protocol_error = err_q;
   end

   lc3b_mem_array #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clk   (clk),
      .reset (reset),
      .we    (arr_we),
      .wmask (be_q),
      .index (arr_index),
      .wdata (wdata_q),
      .re    (arr_re),
      .rdata (arr_rdata)
   );

   assign mem.mem_rdata = arr_rdata;
endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Directed bench for lc3b_mem_responder at LATENCY=4 plus a LATENCY=1 instance.
module tb_lc3b_mem_responder;
   logic clk = 1'b0;
   logic reset;
   logic busy, perr, busy1, perr1;
   int   checks = 0;
   int   errors = 0;

   lc3b_mem_responder_if bus();
   lc3b_mem_responder_if bus1();

   lc3b_mem_responder #(.DEPTH_LOG2(10), .LATENCY(4)) u_dut (
      .clk (clk), .reset (reset), .mem (bus), .busy (busy), .protocol_error (perr)
   );

   lc3b_mem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u_dut1 (
      .clk (clk), .reset (reset), .mem (bus1), .busy (busy1), .protocol_error (perr1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drives one request, returns read data at the resp cycle, latency and mem_resp one cycle later.
   task automatic xfer(input logic wr, input logic [15:0] addr, input logic [1:0] be,
                       input logic [15:0] wd, output logic [15:0] rd, output int lat,
                       output logic resp_after);
      bus.mem_address = addr; bus.mem_byte_enable = be; bus.mem_wdata = wd;
      bus.mem_read = !wr; bus.mem_write = wr;
      lat = 0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         @(posedge clk); #1;
         if (bus.mem_resp) lat = i;
      end
      rd = bus.mem_rdata;
      @(posedge clk); #1;
      resp_after = bus.mem_resp;
      bus.mem_read = 1'b0; bus.mem_write = 1'b0;
   endtask

   task automatic xfer1(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                        output logic [15:0] rd, output int lat, output logic resp_after);
      bus1.mem_address = addr; bus1.mem_byte_enable = 2'b11; bus1.mem_wdata = wd;
      bus1.mem_read = !wr; bus1.mem_write = wr;
      lat = 0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         @(posedge clk); #1;
         if (bus1.mem_resp) lat = i;
      end
      rd = bus1.mem_rdata;
      @(posedge clk); #1;
      resp_after = bus1.mem_resp;
      bus1.mem_read = 1'b0; bus1.mem_write = 1'b0;
   endtask

   task automatic do_write(input string tag, input logic [15:0] addr, input logic [1:0] be,
                           input logic [15:0] wd);
      logic [15:0] rd; int lat; logic ra;
      xfer(1'b1, addr, be, wd, rd, lat, ra);
      check({tag, "_lat"}, lat, 4);
      check({tag, "_pulse1"}, ra, 1'b0);
   endtask

   task automatic do_read(input string tag, input logic [15:0] addr, input logic [15:0] exp);
      logic [15:0] rd; int lat; logic ra;
      xfer(1'b0, addr, 2'b00, 16'h0000, rd, lat, ra);
      check({tag, "_lat"}, lat, 4);
      check({tag, "_data"}, rd, exp);
      check({tag, "_pulse1"}, ra, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [15:0] rd;
      int          lat, seen, t[3], n;
      logic        ra;

      reset = 1'b1;
      bus.mem_address = '0; bus.mem_read = 0; bus.mem_write = 0;
      bus.mem_byte_enable = '0; bus.mem_wdata = '0;
      bus1.mem_address = '0; bus1.mem_read = 0; bus1.mem_write = 0;
      bus1.mem_byte_enable = '0; bus1.mem_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_resp", bus.mem_resp, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_rdata", bus.mem_rdata, 16'h0000);
      check("rst_perr", perr, 1'b0);
      reset = 1'b0;

      do_write("wr_beef", 16'h0042, 2'b11, 16'hBEEF);
      do_read("rd_beef", 16'h0042, 16'hBEEF);

      do_write("pre_1234", 16'h0010, 2'b11, 16'h1234);
      do_write("hi_lane", 16'h0010, 2'b10, 16'hAB00);
      do_read("rd_ab34", 16'h0010, 16'hAB34);
      do_write("lo_lane", 16'h0010, 2'b01, 16'h00CD);
      do_read("rd_abcd", 16'h0010, 16'hABCD);
      do_write("be_none", 16'h0010, 2'b00, 16'hFFFF);
      do_read("rd_be00", 16'h0010, 16'hABCD);

      do_write("wr_alias", 16'h0800, 2'b11, 16'h7E57);
      do_read("rd_alias", 16'h0000, 16'h7E57);

      // Request held continuously: responses must come every LATENCY+1 cycles.
      bus.mem_address = 16'h0042; bus.mem_byte_enable = 2'b00; bus.mem_wdata = 16'h0000;
      bus.mem_read = 1'b1;
      n = 0;
      t[0] = 0; t[1] = 0; t[2] = 0;
      for (int i = 1; i <= 40 && n < 3; i++) begin
         @(posedge clk); #1;
         if (i == 2) check("b2b_busy", busy, 1'b1);
         if (bus.mem_resp) begin
            t[n] = i;
            n++;
         end
      end
      check("b2b_data", bus.mem_rdata, 16'hBEEF);
      @(posedge clk); #1;
      bus.mem_read = 1'b0;
      check("b2b_first", t[0], 4);
      check("b2b_gap1", t[1] - t[0], 5);
      check("b2b_gap2", t[2] - t[1], 5);
      check("perr_clean", perr, 1'b0);

      // Read and write together in IDLE: rejected and flagged.
      bus.mem_read = 1'b1; bus.mem_write = 1'b1;
      @(posedge clk); #1;
      bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.mem_resp) seen++;
         @(posedge clk); #1;
      end
      check("both_noresp", seen, 0);
      check("both_busy", busy, 1'b0);
      check("both_perr", perr, 1'b1);

      // Dropping the request mid-WAIT still completes with the captured read.
      do_reset();
      check("rst2_perr", perr, 1'b0);
      bus.mem_address = 16'h0042; bus.mem_read = 1'b1;
      lat = 0; rd = '0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         if (i == 2) bus.mem_read = 1'b0;
         if (bus.mem_resp && lat == 0) begin
            lat = i;
            rd = bus.mem_rdata;
         end
      end
      check("drop_lat", lat, 4);
      check("drop_data", rd, 16'hBEEF);
      check("drop_perr", perr, 1'b1);

      // Reset during the RESP cycle of a write must suppress the write.
      do_reset();
      do_write("pre_1111", 16'h0020, 2'b11, 16'h1111);
      bus.mem_address = 16'h0020; bus.mem_byte_enable = 2'b11; bus.mem_wdata = 16'h5555;
      bus.mem_write = 1'b1;
      lat = 0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         @(posedge clk); #1;
         if (bus.mem_resp) lat = i;
      end
      check("abort_lat", lat, 4);
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_noresp", bus.mem_resp, 1'b0);
      check("abort_busy", busy, 1'b0);
      bus.mem_write = 1'b0;
      reset = 1'b0;
      do_read("rd_1111", 16'h0020, 16'h1111);

      // LATENCY=1 instance: response in the cycle right after the request.
      xfer1(1'b1, 16'h0006, 16'hCAFE, rd, lat, ra);
      check("l1_wr_lat", lat, 1);
      check("l1_wr_pulse1", ra, 1'b0);
      xfer1(1'b0, 16'h0006, 16'h0000, rd, lat, ra);
      check("l1_rd_lat", lat, 1);
      check("l1_rd_data", rd, 16'hCAFE);
      check("l1_rd_pulse1", ra, 1'b0);
      check("l1_perr", perr1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
